// File: rtl/mag_serial_cmp.sv
// Serial combiner for 2-bit magnitude compare flags, MSB chunk first.
// The first non-equal chunk decides; the result is registered and announced by a done pulse.
//
// state | meaning
// IDLE  | waiting for start; previous result held on outputs
// RUN   | accepting chunks until NCHUNK transfers have occurred
// DONE  | one cycle: publish decision (or error) and pulse done
module mag_serial_cmp #(
    parameter int NCHUNK = 4,
    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic in_valid,
    input  logic agb_i,
    input  logic aeb_i,
    input  logic alb_i,
    output logic in_ready,
    output logic busy,
    output logic done,
    output logic AGB,
    output logic AEB,
    output logic ALB,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0]    EQ   = 3'b010;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    decision;
    logic          err_int;
    logic [2:0]    flags;
    logic          one_hot;

    assign flags    = {agb_i, aeb_i, alb_i};
    assign one_hot  = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    assign in_ready = (state == RUN);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            decision <= EQ;
            err_int  <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            AGB      <= 1'b0;
            AEB      <= 1'b0;
            ALB      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        cnt      <= '0;
                        decision <= EQ;
                        err_int  <= 1'b0;
                    end
                end
                RUN: begin
                    if (in_valid) begin
                        // Malformed flags poison the run but never overwrite the decision.
                        if (!one_hot)
                            err_int <= 1'b1;
                        else if (decision == EQ)
                            decision <= flags;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    err  <= err_int;
                    if (err_int)
                        {AGB, AEB, ALB} <= 3'b000;
                    else
                        {AGB, AEB, ALB} <= decision;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mag_serial_cmp.sv
// Directed bench for mag_serial_cmp: expected results are queued at stimulus time
// and a negedge monitor checks them whenever done pulses.
module tb_mag_serial_cmp;

    logic clk = 1'b0;
    logic rst_n, start, in_valid, agb_i, aeb_i, alb_i;
    logic in_ready, busy, done, AGB, AEB, ALB, err;

    int ntests = 0;
    int nfail = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    logic [3:0] sb[$];

    mag_serial_cmp #(.NCHUNK(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .agb_i(agb_i), .aeb_i(aeb_i), .alb_i(alb_i),
        .in_ready(in_ready), .busy(busy), .done(done),
        .AGB(AGB), .AEB(AEB), .ALB(ALB), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: result {AGB,AEB,ALB,err}
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                logic [3:0] e;
                e = sb.pop_front();
                check("result", 32'({AGB, AEB, ALB, err}), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(output int t);
        start = 1'b1;
        tick();
        t = cyc;
        start = 1'b0;
    endtask

    task automatic chunk(input logic [2:0] f, input string name);
        in_valid = 1'b1;
        {agb_i, aeb_i, alb_i} = f;
        check(name, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0, input string name);
        int k;
        for (k = 0; k < 30; k++) begin
            if (done_cnt != n0) break;
            @(negedge clk);
            #1;
        end
        if (done_cnt == n0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int t, n0;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        agb_i = 1'b0; aeb_i = 1'b0; alb_i = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state and chunks offered in IDLE without start
        check("rst_outs", 32'({AGB, AEB, ALB, err, done, busy, in_ready}), 32'd0);
        n0 = done_cnt;
        in_valid = 1'b1; {agb_i, aeb_i, alb_i} = 3'b100;
        for (int i = 0; i < 5; i++) begin
            check("idle_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        in_valid = 1'b0;
        check("idle_no_done", 32'(done_cnt), 32'(n0));
        check("idle_busy", 32'(busy), 32'd0);

        // 0xB4 vs 0xB1: EQ,EQ,GT,LT -> GT, latency 5
        n0 = done_cnt;
        do_start(t);
        sb.push_back(4'b1000);
        chunk(3'b010, "t2_rdy"); chunk(3'b010, "t2_rdy");
        chunk(3'b100, "t2_rdy"); chunk(3'b001, "t2_rdy");
        wait_done(n0, "t2");
        check("t2_latency", 32'(done_cyc - t), 32'd5);
        tick();
        check("t2_hold_agb", 32'(AGB), 32'd1);
        check("t2_busy_idle", 32'(busy), 32'd0);

        // 0x5A vs 0x5A with a 3-cycle stall; previous result holds until done
        n0 = done_cnt;
        do_start(t);
        sb.push_back(4'b0100);
        chunk(3'b010, "t3_rdy"); chunk(3'b010, "t3_rdy");
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_rdy", 32'(in_ready), 32'd1);
            tick();
        end
        chunk(3'b010, "t3_rdy");
        check("t3_prev_hold", 32'({AGB, AEB, ALB}), 32'b100);
        chunk(3'b010, "t3_rdy");
        check("t3_prev_hold2", 32'({AGB, AEB, ALB}), 32'b100);
        wait_done(n0, "t3");
        check("t3_latency", 32'(done_cyc - t), 32'd8);

        // First chunk LT decides; start during RUN ignored
        tick();
        n0 = done_cnt;
        do_start(t);
        sb.push_back(4'b0010);
        chunk(3'b001, "t4_rdy");
        start = 1'b1;
        chunk(3'b100, "t4_rdy");
        start = 1'b0;
        chunk(3'b100, "t4_rdy"); chunk(3'b100, "t4_rdy");
        wait_done(n0, "t4");
        for (int i = 0; i < 6; i++) tick();
        check("t4_one_done", 32'(done_cnt), 32'(n0 + 1));
        check("t4_no_restart", 32'(busy), 32'd0);

        // Non-one-hot chunk -> err, then clean run clears it
        n0 = done_cnt;
        do_start(t);
        sb.push_back(4'b0001);
        chunk(3'b010, "t5_rdy"); chunk(3'b110, "t5_rdy");
        chunk(3'b010, "t5_rdy"); chunk(3'b010, "t5_rdy");
        wait_done(n0, "t5");
        tick();
        check("t5_err_hold", 32'(err), 32'd1);
        n0 = done_cnt;
        do_start(t);
        sb.push_back(4'b1000);
        chunk(3'b100, "t5b_rdy"); chunk(3'b001, "t5b_rdy");
        chunk(3'b110, "t5b_rdy"); chunk(3'b010, "t5b_rdy");
        sb.pop_back();
        sb.push_back(4'b0001);
        wait_done(n0, "t5b");
        tick();
        n0 = done_cnt;
        do_start(t);
        sb.push_back(4'b1000);
        chunk(3'b100, "t5c_rdy"); chunk(3'b001, "t5c_rdy");
        chunk(3'b010, "t5c_rdy"); chunk(3'b010, "t5c_rdy");
        wait_done(n0, "t5c");
        tick();
        check("t5_err_clear", 32'(err), 32'd0);

        // Reset mid-run: no done, outputs cleared, then normal run
        n0 = done_cnt;
        do_start(t);
        chunk(3'b010, "t6_rdy"); chunk(3'b010, "t6_rdy");
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_rst_outs", 32'({AGB, AEB, ALB, err, busy, in_ready}), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("t6_no_done", 32'(done_cnt), 32'(n0));
        do_start(t);
        sb.push_back(4'b0010);
        chunk(3'b010, "t6b_rdy"); chunk(3'b001, "t6b_rdy");
        chunk(3'b100, "t6b_rdy"); chunk(3'b010, "t6b_rdy");
        wait_done(n0, "t6b");
        check("t6b_latency", 32'(done_cyc - t), 32'd5);

        tick(); tick();
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
